// File: rtl/sync_stage_sequencer_pkg.sv
// sync_stage_sequencer_pkg: sequencer state encoding and default memory wait limit
package sync_stage_sequencer_pkg;
    localparam int SEQ_WAIT_DEF = 16;
    typedef enum logic [3:0] {
        IDLE, BOOT, IF_REQ, IF_MEM, IF_OUT, DEC, RFR, ISS,
        ALU, LSU_IN, DAT_MEM, LSU_OUT, RFW, PCA, ERR
    } seq_state_e;
endpackage

// File: rtl/sync_stage_sequencer_wait_timer.sv
// seq_wait_timer: counts memory wait cycles and flags the last cycle allowed before timeout
module seq_wait_timer
    import sync_stage_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = SEQ_WAIT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_cnt_en,
    output logic o_expired
);
    localparam int TW  = WAIT_MAX > 2 ? $clog2(WAIT_MAX) : 1;
    localparam int LIM = WAIT_MAX > 0 ? WAIT_MAX - 1 : 0;
    logic [TW-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) r_cnt <= '0;
        else if (i_cnt_en)       r_cnt <= r_cnt + 1'b1;
    end
    // WAIT_MAX of zero disables the timeout; the counter then wraps harmlessly
    assign o_expired = (WAIT_MAX != 0) && (r_cnt == LIM[TW-1:0]);
endmodule

// File: rtl/sync_stage_sequencer.sv
// sync_stage_sequencer: clocked one-hot stage-enable sequencer with memory timeout and retire counter
module sync_stage_sequencer
    import sync_stage_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = SEQ_WAIT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             boot_i,
    input  logic             halt_i,
    input  logic             ins_rvalid_i,
    input  logic             dat_rvalid_i,
    input  logic             req_data_i,
    input  logic             data_we_i,
    input  logic             req_rf_w_i,
    output logic             en_ife_in_o,
    output logic             en_ins_mem_o,
    output logic             en_ife_out_o,
    output logic             en_dec_o,
    output logic             en_rfr_o,
    output logic             en_iss_o,
    output logic             en_alu_o,
    output logic             en_lsu_in_o,
    output logic             en_dat_mem_o,
    output logic             en_lsu_out_o,
    output logic             en_rfw_o,
    output logic             en_pca_o,
    output logic             boot_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] instret_o
);
    seq_state_e       r_state, w_nxt;
    logic [CNT_W-1:0] r_instret;
    logic             w_wait, w_rvalid, w_expired;

    assign w_wait   = (r_state == IF_MEM) || (r_state == DAT_MEM);
    assign w_rvalid = (r_state == IF_MEM) ? ins_rvalid_i : dat_rvalid_i;

    seq_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
        .i_clk     (clk_i),
        .i_rst_n   (rst_ni),
        .i_clear   (!w_wait),
        .i_cnt_en  (w_wait && !w_rvalid),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_instret <= '0;
        end else begin
            r_state   <= w_nxt;
            r_instret <= (r_state == PCA) ? r_instret + 1'b1 : r_instret;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE:    w_nxt = start_i ? (boot_i ? BOOT : IF_REQ) : IDLE;
            BOOT:    w_nxt = IF_REQ;
            IF_REQ:  w_nxt = IF_MEM;
            IF_MEM:  w_nxt = ins_rvalid_i ? IF_OUT : (w_expired ? ERR : IF_MEM);
            IF_OUT:  w_nxt = DEC;
            DEC:     w_nxt = RFR;
            RFR:     w_nxt = ISS;
            ISS:     w_nxt = ALU;
            ALU:     w_nxt = req_data_i ? LSU_IN : (req_rf_w_i ? RFW : PCA);
            LSU_IN:  w_nxt = DAT_MEM;
            DAT_MEM: w_nxt = dat_rvalid_i ? LSU_OUT : (w_expired ? ERR : DAT_MEM);
            LSU_OUT: w_nxt = data_we_i ? PCA : RFW;
            RFW:     w_nxt = PCA;
            PCA:     w_nxt = halt_i ? IDLE : IF_REQ;
            ERR:     w_nxt = ERR;
            default: w_nxt = IDLE;
        endcase
    end

    assign en_ife_in_o  = r_state == IF_REQ;
    assign en_ins_mem_o = r_state == IF_MEM;
    assign en_ife_out_o = r_state == IF_OUT;
    assign en_dec_o     = r_state == DEC;
    assign en_rfr_o     = r_state == RFR;
    assign en_iss_o     = r_state == ISS;
    assign en_alu_o     = r_state == ALU;
    assign en_lsu_in_o  = r_state == LSU_IN;
    assign en_dat_mem_o = r_state == DAT_MEM;
    assign en_lsu_out_o = r_state == LSU_OUT;
    assign en_rfw_o     = r_state == RFW;
    assign en_pca_o     = (r_state == PCA) || (r_state == BOOT);
    assign boot_o       = r_state == BOOT;
    assign busy_o       = (r_state != IDLE) && (r_state != ERR);
    assign err_o        = r_state == ERR;
    assign instret_o    = r_instret;
endmodule

// File: tb/tb_sync_stage_sequencer.sv
// tb_sync_stage_sequencer: instruction-level plan model feeding a per-cycle expectation scoreboard
module tb_sync_stage_sequencer;
    typedef enum int {
        T_IFI, T_IM, T_IFO, T_DEC, T_RFR, T_ISS, T_ALU,
        T_LI, T_DM, T_LO, T_RFW, T_PCA, T_IDLE, T_BOOT, T_ERR
    } t_stg;
    typedef struct {
        t_stg        s;
        logic [11:0] en;
        logic        bt, by, er;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 0, rst_ni = 0, start_i = 0, boot_i = 0, halt_i = 0;
    logic ins_rvalid_i = 0, dat_rvalid_i = 0, req_data_i = 0, data_we_i = 0, req_rf_w_i = 0;
    logic en_ife_in_o, en_ins_mem_o, en_ife_out_o, en_dec_o, en_rfr_o, en_iss_o, en_alu_o;
    logic en_lsu_in_o, en_dat_mem_o, en_lsu_out_o, en_rfw_o, en_pca_o;
    logic boot_o, busy_o, err_o;
    logic [3:0] instret_o;

    exp_t       exp_q[$];
    logic [3:0] cnt_m = '0;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    sync_stage_sequencer #(.WAIT_MAX(4), .CNT_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .boot_i(boot_i), .halt_i(halt_i),
        .ins_rvalid_i(ins_rvalid_i), .dat_rvalid_i(dat_rvalid_i), .req_data_i(req_data_i),
        .data_we_i(data_we_i), .req_rf_w_i(req_rf_w_i),
        .en_ife_in_o(en_ife_in_o), .en_ins_mem_o(en_ins_mem_o), .en_ife_out_o(en_ife_out_o),
        .en_dec_o(en_dec_o), .en_rfr_o(en_rfr_o), .en_iss_o(en_iss_o), .en_alu_o(en_alu_o),
        .en_lsu_in_o(en_lsu_in_o), .en_dat_mem_o(en_dat_mem_o), .en_lsu_out_o(en_lsu_out_o),
        .en_rfw_o(en_rfw_o), .en_pca_o(en_pca_o), .boot_o(boot_o), .busy_o(busy_o),
        .err_o(err_o), .instret_o(instret_o)
    );

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [11:0] en;
            e  = exp_q.pop_front();
            en = {en_ife_in_o, en_ins_mem_o, en_ife_out_o, en_dec_o, en_rfr_o, en_iss_o,
                  en_alu_o, en_lsu_in_o, en_dat_mem_o, en_lsu_out_o, en_rfw_o, en_pca_o};
            n_chk++;
            if ({en, boot_o, busy_o, err_o, instret_o} !== {e.en, e.bt, e.by, e.er, e.cnt}) begin
                n_fail++;
                $display("FAIL cyc_%s t=%0t got en=%h boot=%b busy=%b err=%b cnt=%0d exp en=%h boot=%b busy=%b err=%b cnt=%0d",
                         e.s.name(), $time, en, boot_o, busy_o, err_o, instret_o,
                         e.en, e.bt, e.by, e.er, e.cnt);
            end
        end
    end

    function automatic logic r();
        return 1'($urandom_range(1));
    endfunction

    task automatic step(input t_stg s, input logic st, bt, hl, irv, drv, rqd, dwe, rfw, rn);
        exp_t e;
        start_i = st; boot_i = bt; halt_i = hl; ins_rvalid_i = irv; dat_rvalid_i = drv;
        req_data_i = rqd; data_we_i = dwe; req_rf_w_i = rfw; rst_ni = rn;
        e.s   = s;
        e.en  = (s <= T_PCA) ? 12'h800 >> s : (s == T_BOOT ? 12'h001 : 12'h000);
        e.bt  = s == T_BOOT;
        e.by  = !(s == T_IDLE || s == T_ERR);
        e.er  = s == T_ERR;
        e.cnt = cnt_m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!rn) cnt_m = '0;
        else if (s == T_PCA) cnt_m = cnt_m + 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(T_IDLE, 0, r(), r(), r(), r(), r(), r(), r(), 1);
    endtask

    task automatic launch(input logic bt);
        step(T_IDLE, 1, bt, r(), r(), r(), r(), r(), r(), 1);
        if (bt) step(T_BOOT, r(), r(), r(), r(), r(), r(), r(), r(), 1);
    endtask

    // cls: 0 ALU-op, 1 branch, 2 load, 3 store; di/dd extra wait cycles before rvalid
    task automatic run_insn(input int cls, di, dd, input logic halt, input int rst_at);
        t_stg p[$];
        t_stg s;
        logic irv, drv, rqd, dwe, rfw, hl, rn;
        int   dm_last;
        p.push_back(T_IFI);
        for (int i = 0; i <= di; i++) p.push_back(T_IM);
        p.push_back(T_IFO); p.push_back(T_DEC); p.push_back(T_RFR);
        p.push_back(T_ISS); p.push_back(T_ALU);
        if (cls >= 2) begin
            p.push_back(T_LI);
            for (int i = 0; i <= dd; i++) p.push_back(T_DM);
            p.push_back(T_LO);
        end
        if (cls == 0 || cls == 2) p.push_back(T_RFW);
        p.push_back(T_PCA);
        dm_last = di + 8 + dd;
        for (int i = 0; i < p.size(); i++) begin
            s   = p[i];
            irv = (s == T_IM)  ? (i == di + 1) : r();
            drv = (s == T_DM)  ? (i == dm_last) : r();
            rqd = (s == T_ALU) ? (cls >= 2) : r();
            rfw = (s == T_ALU) ? (cls == 0 ? 1'b1 : cls == 1 ? 1'b0 : r()) : r();
            dwe = (s == T_LO)  ? (cls == 3) : r();
            hl  = (s == T_PCA) ? halt : r();
            rn  = i != rst_at;
            step(s, r(), r(), hl, irv, drv, rqd, dwe, rfw, rn);
            if (!rn) return;
        end
    endtask

    initial begin
        rst_ni = 0;
        @(posedge clk);
        #1;
        rst_ni = 1;
        idle(3);
        launch(1);
        run_insn(0, 0, 0, 1, -1);
        idle(1);
        launch(0);
        run_insn(2, 0, 3, 0, 9);
        idle(2);
        launch(0);
        run_insn(2, 0, 3, 0, -1);
        run_insn(3, 1, 2, 0, -1);
        run_insn(1, 2, 0, 1, -1);
        idle(2);
        launch(0);
        step(T_IFI, r(), r(), r(), r(), r(), r(), r(), r(), 1);
        for (int i = 0; i < 4; i++) step(T_IM, r(), r(), r(), 0, r(), r(), r(), r(), 1);
        for (int i = 0; i < 4; i++) step(T_ERR, 1, r(), r(), r(), r(), r(), r(), r(), 1);
        step(T_ERR, 1, r(), r(), r(), r(), r(), r(), r(), 0);
        idle(1);
        launch(0);
        run_insn(0, 3, 0, 1, -1);
        idle(1);
        launch(r());
        for (int k = 0; k < 24; k++)
            run_insn(int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
                     k == 23, -1);
        idle(3);
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
